// File: rtl/snn_pkg.sv
// snn_pkg: shared definitions for the spiking-neuron update path.
//   FP32_W          - width of an IEEE-754 single-precision word
//   V_RESET         - default reset potential (+0.0)
//   ID_W_DEF        - default neuron ID width
//   REFRACT_W_DEF   - default refractory counter width
//   neuron_id_t     - neuron ID type at the default width
//   refract_t       - refractory count type at the default width
package snn_pkg;
  localparam int          FP32_W        = 32;
  localparam logic [31:0] V_RESET       = 32'h0000_0000;
  localparam int          ID_W_DEF      = 5;
  localparam int          REFRACT_W_DEF = 4;

  typedef logic [ID_W_DEF-1:0]      neuron_id_t;
  typedef logic [REFRACT_W_DEF-1:0] refract_t;
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: parameterised first-word-fall-through FIFO.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push, din  - write request/data; ignored when full
//   pop        - read request; ignored when empty
//   dout       - head entry, 0 while empty
//   full/empty - occupancy flags
module spike_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Mask the head while empty so stale storage never leaks out after a reset.
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spike_event_controller.sv
// spike_event_controller: spike decision, refractory tracking, potential
// writeback and spike queueing for one neuron update per cycle.
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - update request handshake (ready = FIFO not full)
//   in_neuron_id/potential/greater- neuron, FP32 potential, threshold-compare result
//   cfg_v_reset                   - potential written back on spike or while refractory
//   cfg_refract_period            - refractory length loaded on spike
//   timestep_tick                 - decrements all nonzero refractory counters
//   wb_valid/neuron_id/potential  - registered one-cycle writeback
//   spk_valid/ready/neuron_id     - FWFT spike FIFO output
//   spike_count                   - pushes since last tick (only with SPIKE_COUNT_EN)
// Optional feature macro: SPIKE_COUNT_EN.
module spike_event_controller
  import snn_pkg::*;
#(
  parameter int ID_W       = ID_W_DEF,
  parameter int REFRACT_W  = REFRACT_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
`ifdef SPIKE_COUNT_EN
  output logic [15:0]          spike_count,
`endif
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_neuron_id,
  input  logic [FP32_W-1:0]    in_potential,
  input  logic                 in_greater,
  input  logic [FP32_W-1:0]    cfg_v_reset,
  input  logic [REFRACT_W-1:0] cfg_refract_period,
  input  logic                 timestep_tick,
  output logic                 wb_valid,
  output logic [ID_W-1:0]      wb_neuron_id,
  output logic [FP32_W-1:0]    wb_potential,
  output logic                 spk_valid,
  input  logic                 spk_ready,
  output logic [ID_W-1:0]      spk_neuron_id
);
  localparam int NUM_NEURONS = 2**ID_W;

  logic [REFRACT_W-1:0] refract [NUM_NEURONS];
  logic                 fifo_full, fifo_empty;
  logic                 accept, refractory, spike;
  logic [FP32_W-1:0]    wb_next;

  assign in_ready   = !fifo_full;
  assign spk_valid  = !fifo_empty;
  assign accept     = in_valid && in_ready;
  assign refractory = (refract[in_neuron_id] != '0);
  assign spike      = accept && !refractory && in_greater;
  // Refractory neurons are clamped to v_reset regardless of the compare result.
  assign wb_next    = (refractory || in_greater) ? cfg_v_reset : in_potential;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) refract[i] <= '0;
      wb_valid     <= 1'b0;
      wb_neuron_id <= '0;
      wb_potential <= '0;
    end else begin
      // A spike load on the same neuron overrides that cycle's tick decrement.
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (spike && in_neuron_id == ID_W'(i))
          refract[i] <= cfg_refract_period;
        else if (timestep_tick && refract[i] != '0)
          refract[i] <= refract[i] - 1'b1;
      end
      wb_valid <= accept;
      if (accept) begin
        wb_neuron_id <= in_neuron_id;
        wb_potential <= wb_next;
      end
    end
  end

  spike_fifo #(.W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (spike),
    .din   (in_neuron_id),
    .pop   (spk_ready),
    .dout  (spk_neuron_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      spike_count <= '0;
    else if (timestep_tick)
      spike_count <= spike ? 16'd1 : 16'd0;
    else if (spike && spike_count != 16'hFFFF)
      spike_count <= spike_count + 16'd1;
  end
`endif
endmodule
